bit_serial_subtractor: RTL



---
 rtl/bit_serial_subtractor_if.sv | 26 ++
 rtl/bit_serial_subtractor.sv | 116 +++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
//   master : drives start, A, B, B_in; observes busy, done, D, B_out, V
//   slave  : the subtractor side of the same signals
interface bit_serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             B_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             B_out;
    logic             V;

    modport master (
        output start, A, B, B_in,
        input  busy, done, D, B_out, V
    );

    modport slave (
        input  start, A, B, B_in,
        output busy, done, D, B_out, V
    );
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - B_in, LSB first,
// one full-subtractor cell per cycle with a registered borrow.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of bit_serial_subtractor_if
//            (start/A/B/B_in in, busy/done/D/B_out/V out)
//
// state | meaning
// IDLE  | waiting for start; operands loaded on the accepting edge
// SHIFT | one difference bit per cycle, WIDTH cycles
// DONE  | one-cycle done pulse with fresh D/B_out/V
module bit_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    bit_serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_v;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_borrow_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_nxt;

    assign w_a          = r_sa[0];
    assign w_b          = r_sb[0];
    assign w_d          = w_a ^ w_b ^ r_br;
    assign w_borrow_nxt = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_last       = (r_cnt == CW'(WIDTH - 1));
    assign w_sr_nxt     = {w_d, r_sr[WIDTH-1:1]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sr   <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
            r_v    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_sa  <= bus.A;
                        r_sb  <= bus.B;
                        r_br  <= bus.B_in;
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_sr  <= w_sr_nxt;
                    r_br  <= w_borrow_nxt;
                    r_cnt <= w_last ? r_cnt : r_cnt + CW'(1);
                    // Results are published on the edge entering DONE so the
                    // visible outputs only move once per operation. On the MSB
                    // cycle r_br is the borrow into the MSB, so overflow is
                    // that borrow XOR the borrow out.
                    if (w_last) begin
                        r_d    <= w_sr_nxt;
                        r_bout <= w_borrow_nxt;
                        r_v    <= r_br ^ w_borrow_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (r_state != IDLE);
    assign bus.done  = (r_state == DONE);
    assign bus.D     = r_d;
    assign bus.B_out = r_bout;
    assign bus.V     = r_v;
endmodule
